// File: rtl/btn_pkg.sv
// Shared types and defaults for the button event logic and its tick prescaler.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  localparam int CLK_HZ           = 12_000_000;
  // One hold tick per millisecond at the default clock.
  localparam int TICK_DIV_DEFAULT = CLK_HZ / 1000;

endpackage

// File: rtl/tick_gen.sv
// Free-running TICK_DIV prescaler with synchronous clear and count enable.
module tick_gen #(
  parameter int TICK_DIV = btn_pkg::TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Clear wins so a fresh press always starts a full tick period.
  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/long/repeat pulses plus hold state and time.
module button_event
  import btn_pkg::*;
#(
  parameter logic ACTIVE_LEVEL = 1'b1,
  parameter int   TICK_DIV     = TICK_DIV_DEFAULT,
  parameter int   LONG_TICKS   = 500,
  parameter int   REPEAT_TICKS = 100,
  parameter int   HW           = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          db_in,
  input  logic          enable,
  output logic          press_pulse,
  output logic          release_pulse,
  output logic          long_pulse,
  output logic          repeat_pulse,
  output logic          held,
  output logic [HW-1:0] hold_ticks,
  output btn_state_e    dbg_state
);

  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [HW-1:0] LONG_HW = HW'(LONG_TICKS);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_TICKS);

  btn_state_e    state_q;
  logic          prev_q;
  logic          press_q, release_q, long_q, repeat_q;
  logic [HW-1:0] hold_q;
  logic [RW-1:0] rep_q;

  logic          rise, fall, tick;
  logic [HW-1:0] hold_inc;
  logic [RW-1:0] rep_inc;

  assign rise     = (db_in == ACTIVE_LEVEL) && (prev_q != ACTIVE_LEVEL);
  assign fall     = (db_in != ACTIVE_LEVEL) && (prev_q == ACTIVE_LEVEL);
  assign hold_inc = (hold_q == '1) ? hold_q : hold_q + 1'b1;
  assign rep_inc  = rep_q + 1'b1;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (rise || (state_q == IDLE)),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      prev_q    <= ~ACTIVE_LEVEL;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      hold_q    <= '0;
      rep_q     <= '0;
    end else begin
      prev_q    <= db_in;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise && enable) begin
            state_q <= PRESS;
            press_q <= 1'b1;
            hold_q  <= '0;
            rep_q   <= '0;
          end
        end
        default: begin
          if (tick) hold_q <= hold_inc;
          // Disable drops out silently; a release beats any threshold on the same edge.
          if (!enable) begin
            state_q <= IDLE;
          end else if (fall) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
          end else if (state_q == PRESS) begin
            if (tick && (hold_inc == LONG_HW)) begin
              state_q <= REPEAT;
              long_q  <= 1'b1;
              rep_q   <= '0;
            end
          end else if (tick) begin
            if (rep_inc == REP_MAX) begin
              repeat_q <= 1'b1;
              rep_q    <= '0;
            end else begin
              rep_q <= rep_inc;
            end
          end
        end
      endcase
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = (state_q != IDLE);
  assign hold_ticks    = hold_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event: TICK_DIV=4, LONG_TICKS=5, REPEAT_TICKS=2; second instance with HW=3.
module tb_button_event;
  import btn_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic db_in = 1'b0;
  logic db_in_b = 1'b0;
  logic enable = 1'b1;

  logic        press_a, release_a, long_a, repeat_a, held_a;
  logic [15:0] hold_a;
  btn_state_e  st_a;
  logic        press_b, release_b, long_b, repeat_b, held_b;
  logic [2:0]  hold_b;
  btn_state_e  st_b;

  int cyc = 0;
  int base = 0;
  int checks = 0;
  int failures = 0;

  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];

  button_event #(
    .ACTIVE_LEVEL(1'b1), .TICK_DIV(4), .LONG_TICKS(5), .REPEAT_TICKS(2), .HW(16)
  ) dut_a (
    .clk(clk), .reset(reset), .db_in(db_in), .enable(enable),
    .press_pulse(press_a), .release_pulse(release_a), .long_pulse(long_a),
    .repeat_pulse(repeat_a), .held(held_a), .hold_ticks(hold_a), .dbg_state(st_a)
  );

  button_event #(
    .ACTIVE_LEVEL(1'b1), .TICK_DIV(4), .LONG_TICKS(5), .REPEAT_TICKS(2), .HW(3)
  ) dut_b (
    .clk(clk), .reset(reset), .db_in(db_in_b), .enable(enable),
    .press_pulse(press_b), .release_pulse(release_b), .long_pulse(long_b),
    .repeat_pulse(repeat_b), .held(held_b), .hold_ticks(hold_b), .dbg_state(st_b)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Event monitor: kind*1000 + relative cycle; kinds 1..4 dut_a, 9..12 dut_b, 7/15 = overlap.
  always @(negedge clk) begin
    int na, nb, rel;
    rel = cyc - base;
    na = int'(press_a) + int'(release_a) + int'(long_a) + int'(repeat_a);
    nb = int'(press_b) + int'(release_b) + int'(long_b) + int'(repeat_b);
    if (na > 1) obs_q.push_back(32'(7000 + rel));
    else if (press_a)   obs_q.push_back(32'(1000 + rel));
    else if (release_a) obs_q.push_back(32'(2000 + rel));
    else if (long_a)    obs_q.push_back(32'(3000 + rel));
    else if (repeat_a)  obs_q.push_back(32'(4000 + rel));
    if (nb > 1) obs_q.push_back(32'(15000 + rel));
    else if (press_b)   obs_q.push_back(32'(9000 + rel));
    else if (release_b) obs_q.push_back(32'(10000 + rel));
    else if (long_b)    obs_q.push_back(32'(11000 + rel));
    else if (repeat_b)  obs_q.push_back(32'(12000 + rel));
  end

  // checking / scoreboard
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic exp_ev(input int kind, input int c);
    exp_q.push_back(32'(kind * 1000 + c));
  endtask

  task automatic compare_sb(input string tag);
    int n;
    check({tag, " event count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s ev%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    db_in = 1'b0;
    db_in_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    base = cyc;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_to(input int n);
    while (cyc - base < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst press", 32'(press_a), 0);
    check("rst release", 32'(release_a), 0);
    check("rst long", 32'(long_a), 0);
    check("rst repeat", 32'(repeat_a), 0);
    check("rst held", 32'(held_a), 0);
    check("rst hold_ticks", 32'(hold_a), 0);
    check("rst state", 32'(st_a), 32'(IDLE));

    // short press
    wait_to(10); db_in = 1'b1;
    wait_to(15); check("short held", 32'(held_a), 1);
    check("short hold@15", 32'(hold_a), 1);
    wait_to(18); db_in = 1'b0;
    wait_to(30);
    check("short hold_ticks", 32'(hold_a), 2);
    check("short held end", 32'(held_a), 0);
    exp_ev(1, 11); exp_ev(2, 19);
    compare_sb("short");

    // long hold with repeats
    do_reset();
    wait_to(10); db_in = 1'b1;
    wait_to(20); check("long held@20", 32'(held_a), 1);
    check("long state@20", 32'(st_a), 32'(PRESS));
    wait_to(40); check("long held@40", 32'(held_a), 1);
    check("long state@40", 32'(st_a), 32'(REPEAT));
    wait_to(56); check("long hold@56", 32'(hold_a), 11);
    db_in = 1'b0;
    wait_to(60);
    check("long hold kept", 32'(hold_a), 11);
    check("long held end", 32'(held_a), 0);
    exp_ev(1, 11); exp_ev(3, 31); exp_ev(4, 39); exp_ev(4, 47); exp_ev(4, 55); exp_ev(2, 57);
    compare_sb("long");

    // release coinciding with long threshold
    do_reset();
    wait_to(10); db_in = 1'b1;
    wait_to(30); db_in = 1'b0;
    wait_to(35);
    check("thr state", 32'(st_a), 32'(IDLE));
    check("thr hold", 32'(hold_a), 5);
    exp_ev(1, 11); exp_ev(2, 31);
    compare_sb("thr");

    // reset mid-hold
    do_reset();
    wait_to(10); db_in = 1'b1;
    wait_to(25); reset = 1'b1;
    wait_to(26);
    check("mid rst held", 32'(held_a), 0);
    check("mid rst hold", 32'(hold_a), 0);
    check("mid rst state", 32'(st_a), 32'(IDLE));
    wait_to(27); reset = 1'b0;
    wait_to(28); check("mid rst re-held", 32'(held_a), 1);
    wait_to(32);
    exp_ev(1, 11); exp_ev(1, 28);
    compare_sb("midrst");

    // enable gating
    enable = 1'b0;
    do_reset();
    wait_to(10); db_in = 1'b1;
    wait_to(15); enable = 1'b1;
    wait_to(25); check("en held gated", 32'(held_a), 0);
    db_in = 1'b0;
    wait_to(30); db_in = 1'b1;
    wait_to(35); check("en held", 32'(held_a), 1);
    wait_to(40); enable = 1'b0;
    wait_to(45); check("en drop held", 32'(held_a), 0);
    check("en drop state", 32'(st_a), 32'(IDLE));
    db_in = 1'b0;
    wait_to(50);
    enable = 1'b1;
    exp_ev(1, 31);
    compare_sb("enable");

    // saturation on HW=3 instance
    do_reset();
    wait_to(10); db_in_b = 1'b1;
    wait_to(30); check("sat hold@30", 32'(hold_b), 4);
    wait_to(40); check("sat hold@40", 32'(hold_b), 7);
    wait_to(64); check("sat hold@64", 32'(hold_b), 7);
    check("sat held", 32'(held_b), 1);
    db_in_b = 1'b0;
    wait_to(68);
    exp_ev(9, 11); exp_ev(11, 31); exp_ev(12, 39); exp_ev(12, 47); exp_ev(12, 55);
    exp_ev(12, 63); exp_ev(10, 65);
    compare_sb("sat");

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Downstream of the button debouncer: consumes its clean level and turns it into single-cycle control events for the velocity-profile logic.
- Events are press, release, long-press, and auto-repeat while held.
- Also exports the hold state and elapsed hold time, so the parameter-adjust logic can step velocity and acceleration settings from one button.

Parameters:
- ACTIVE_LEVEL, 1, db_in level that means "pressed".
- TICK_DIV, 12000, clk cycles per hold tick (1 ms at 12 MHz).
- LONG_TICKS, 500, ticks from press to long_pulse; must be at least 1.
- REPEAT_TICKS, 100, ticks between repeat_pulse events after long_pulse; must be at least 1.
- HW, 16, width of hold_ticks.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- db_in  in  1  debounced button level, already synchronous to clk
- enable  in  1  1 = event generation active
- press_pulse  out  1  one-cycle pulse on press edge
- release_pulse  out  1  one-cycle pulse on release edge
- long_pulse  out  1  one-cycle pulse when hold reaches LONG_TICKS
- repeat_pulse  out  1  one-cycle pulse every REPEAT_TICKS after long_pulse
- held  out  1  level; 1 while FSM is not in IDLE
- hold_ticks  out  HW  ticks elapsed since press; saturates at 2^HW-1

Behaviour:
- Clocking and reset (already decided):
  - One clock, clk. Reset is synchronous and active-high, port name reset.
  - In reset, all outputs are 0, the FSM goes to IDLE, and all counters are 0.
  - The prev register loads the inactive level (~ACTIVE_LEVEL). So a button held through reset release gives press_pulse 1 cycle after reset deasserts (enable permitting).
- Edge detection:
  - prev <= db_in every cycle, regardless of enable.
  - rise = (db_in == ACTIVE_LEVEL) && (prev != ACTIVE_LEVEL); fall is the mirror.
  - All pulse outputs are registered, so latency is 1 clk from the db_in change to press_pulse / release_pulse.
- Tick prescaler:
  - tick_cnt is cleared on the rise cycle and counts 0..TICK_DIV-1 while the FSM is not IDLE.
  - tick is asserted when tick_cnt == TICK_DIV-1, then tick_cnt wraps to 0.
  - In IDLE the prescaler is held at 0.
- FSM states: IDLE, PRESS, REPEAT.
  - IDLE: on rise with enable=1, go to PRESS, pulse press_pulse, clear hold_ticks and rep_cnt. A level held active without a rise stays in IDLE.
  - PRESS: hold_ticks increments on each tick. On the tick where hold_ticks becomes LONG_TICKS, pulse long_pulse, clear rep_cnt, and go to REPEAT.
  - REPEAT: hold_ticks keeps incrementing. rep_cnt increments on each tick; on the tick where it reaches REPEAT_TICKS, pulse repeat_pulse and reset rep_cnt to 0.
  - Any non-IDLE state: fall goes to IDLE and pulses release_pulse. hold_ticks keeps its final value until the next press.
- Timing: long_pulse comes exactly LONG_TICKS*TICK_DIV cycles after press_pulse. Each repeat_pulse comes REPEAT_TICKS*TICK_DIV cycles after the previous long_pulse or repeat_pulse.
- Simultaneous events:
  - fall on the same cycle as a long or repeat threshold: release wins; only release_pulse fires.
  - rise and fall cannot coincide.
  - At most one pulse output is high in any cycle.
- enable:
  - Deasserting enable forces IDLE on the next edge with no release_pulse; held goes to 0.
  - Re-asserting enable while the button is held generates no event until a fresh rise.
- hold_ticks saturates at all-ones and does not wrap. repeat_pulse continues after saturation.
- Reset mid-hold: everything returns to reset values immediately and no pulse fires. prev loads the inactive level, so a button still held gives a fresh press_pulse after reset release.

Decomposition:
- Shared package btn_pkg:
  - state enum: IDLE, PRESS, REPEAT.
  - default constants: CLK_HZ=12_000_000, TICK_DIV default.
- One sub-module, tick_gen: a TICK_DIV prescaler with sync clear and enable, output tick. The debouncer's users can reuse it for other ms-scale timing.

Test Plan (bench values: TICK_DIV=4, LONG_TICKS=5, REPEAT_TICKS=2):
- Short press: db_in rises at cycle 10 and falls at 18 -> press_pulse at cycle 11, release_pulse at 19, no long_pulse, hold_ticks=2.
- Long hold: db_in rises at cycle 10 and holds -> press_pulse at 11, long_pulse at 31, repeat_pulse at 39, 47, 55; held=1 throughout.
- Release on threshold: db_in falls so that fall coincides with the long threshold cycle -> release_pulse only, no long_pulse, FSM returns to IDLE.
- Reset mid-hold: reset asserted at cycle 25 during hold and released at 27 with db_in still high -> all outputs 0 at cycle 26; press_pulse at cycle 28.
- enable gating: enable=0 at a rise -> no pulses. enable goes to 1 while held -> nothing. Then release and press -> normal press_pulse.
- Saturation: HW=3, hold 12 ticks -> hold_ticks sticks at 7 and repeat_pulse continues.
